// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running column/row counters with registered
// sync, blanking and start-of-line/frame strobes aligned to the counters.
module vga_timing_gen #(
    parameter int HVID   = 1024,
    parameter int HFP    = 24,
    parameter int HS     = 136,
    parameter int HBP    = 160,
    parameter int VVID   = 768,
    parameter int VFP    = 3,
    parameter int VS     = 6,
    parameter int VBP    = 29,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    localparam int HTOT  = HVID + HFP + HS + HBP,
    localparam int VTOT  = VVID + VFP + VS + VBP,
    localparam int CW    = $clog2(HTOT),
    localparam int RW    = $clog2(VTOT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          hsync,
    output logic          vsync,
    output logic          vid_active,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    // Region boundaries, compared at 32 bits so an edge equal to HTOT/VTOT
    // cannot alias when the total is a power of two.
    localparam int HS_BEG = HVID + HFP;
    localparam int HS_END = HVID + HFP + HS;
    localparam int VS_BEG = VVID + VFP;
    localparam int VS_END = VVID + VFP + VS;

    // Cleared by reset so the first cycle out of reset presents (0,0)
    // with its strobes instead of stepping straight to column 1.
    logic          running;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic [7:0]    fc_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          vid_nxt;

    // Next position of the raster counters and the frame counter.
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        fc_nxt  = frame_count;
        if (!running) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (col == CW'(HTOT - 1)) begin
            col_nxt = '0;
            if (row == RW'(VTOT - 1)) begin
                row_nxt = '0;
                fc_nxt  = frame_count + 8'd1;
            end else begin
                row_nxt = row + 1'b1;
            end
        end else begin
            col_nxt = col + 1'b1;
        end
    end

    // Region decode from the next position so the registered outputs line up with col/row.
    always_comb begin
        hs_nxt  = (int'(col_nxt) >= HS_BEG) && (int'(col_nxt) < HS_END);
        vs_nxt  = (int'(row_nxt) >= VS_BEG) && (int'(row_nxt) < VS_END);
        vid_nxt = (int'(col_nxt) < HVID) && (int'(row_nxt) < VVID);
    end

    // Counter and output registers; reset parks everything at the idle levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            running     <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_count <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vid_active  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            col         <= col_nxt;
            row         <= row_nxt;
            frame_count <= fc_nxt;
            hsync       <= hs_nxt ? HS_POL : ~HS_POL;
            vsync       <= vs_nxt ? VS_POL : ~VS_POL;
            vid_active  <= vid_nxt;
            line_start  <= (col_nxt == '0);
            frame_start <= (col_nxt == '0) && (row_nxt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance and a small
// positive-polarity instance share clock and reset; both are compared
// every cycle against a raster model built from position arithmetic.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic [10:0] d_col;
    logic [9:0]  d_row;
    logic        d_hs, d_vs, d_vid, d_ls, d_fs;
    logic [7:0]  d_fc;

    logic [3:0]  s_col;
    logic [2:0]  s_row;
    logic        s_hs, s_vs, s_vid, s_ls, s_fs;
    logic [7:0]  s_fc;

    vga_timing_gen dut_def (
        .clk(clk), .reset(reset),
        .col(d_col), .row(d_row), .hsync(d_hs), .vsync(d_vs),
        .vid_active(d_vid), .line_start(d_ls), .frame_start(d_fs),
        .frame_count(d_fc)
    );

    vga_timing_gen #(
        .HVID(8), .HFP(2), .HS(3), .HBP(1),
        .VVID(4), .VFP(1), .VS(2), .VBP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_small (
        .clk(clk), .reset(reset),
        .col(s_col), .row(s_row), .hsync(s_hs), .vsync(s_vs),
        .vid_active(s_vid), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc)
    );

    typedef struct {
        int col;
        int row;
        int fc;
        bit started;
        bit hs;
        bit vs;
        bit vid;
        bit ls;
        bit fs;
    } m_t;

    m_t md, ms;
    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Raster position after one clock, and the expected outputs at that position.
    function automatic m_t step(m_t s, bit rst, int hvid, int hfp, int hsw, int hbp,
                                int vvid, int vfp, int vsw, int vbp, bit hpol, bit vpol);
        m_t n = s;
        int htot = hvid + hfp + hsw + hbp;
        int vtot = vvid + vfp + vsw + vbp;
        if (rst) begin
            n.col = 0; n.row = 0; n.fc = 0; n.started = 0;
            n.hs = !hpol; n.vs = !vpol; n.vid = 0; n.ls = 0; n.fs = 0;
            return n;
        end
        if (!n.started) begin
            n.started = 1; n.col = 0; n.row = 0;
        end else begin
            n.col = n.col + 1;
            if (n.col == htot) begin
                n.col = 0;
                n.row = n.row + 1;
                if (n.row == vtot) begin
                    n.row = 0;
                    n.fc = (n.fc + 1) % 256;
                end
            end
        end
        n.vid = (n.col < hvid) && (n.row < vvid);
        n.hs  = (n.col >= hvid + hfp && n.col < hvid + hfp + hsw) ? hpol : !hpol;
        n.vs  = (n.row >= vvid + vfp && n.row < vvid + vfp + vsw) ? vpol : !vpol;
        n.ls  = (n.col == 0);
        n.fs  = (n.col == 0) && (n.row == 0);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock, update both models with the reset level seen at the edge, compare.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        md = step(md, reset, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0);
        ms = step(ms, reset, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1);
        chk("def_col", 32'(d_col), md.col);
        chk("def_row", 32'(d_row), md.row);
        chk("def_hsync", 32'(d_hs), int'(md.hs));
        chk("def_vsync", 32'(d_vs), int'(md.vs));
        chk("def_vid_active", 32'(d_vid), int'(md.vid));
        chk("def_line_start", 32'(d_ls), int'(md.ls));
        chk("def_frame_start", 32'(d_fs), int'(md.fs));
        chk("def_frame_count", 32'(d_fc), md.fc);
        chk("sml_col", 32'(s_col), ms.col);
        chk("sml_row", 32'(s_row), ms.row);
        chk("sml_hsync", 32'(s_hs), int'(ms.hs));
        chk("sml_vsync", 32'(s_vs), int'(ms.vs));
        chk("sml_vid_active", 32'(s_vid), int'(ms.vid));
        chk("sml_line_start", 32'(s_ls), int'(ms.ls));
        chk("sml_frame_start", 32'(s_fs), int'(ms.fs));
        chk("sml_frame_count", 32'(s_fc), ms.fc);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;

        // Three default lines plus a bit: line wraps and row steps on the large instance.
        repeat (3 * 1344 + 40) cycle();

        // Mid-frame resets of random length at random points.
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(1500, 50)) cycle();
            reset = 1'b1;
            repeat ($urandom_range(3, 1)) cycle();
            reset = 1'b0;
        end

        // 256+ small frames from a clean reset: frame_count wraps 255 -> 0.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (256 * 112 + 150) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter HVID, default 1024, meaning visible pixels per line.
REQ-002 SHALL have parameter HFP, default 24, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter HS, default 136, meaning hsync width in pixels.
REQ-004 SHALL have parameter HBP, default 160, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter VVID, default 768, meaning visible lines per frame.
REQ-006 SHALL have parameter VFP, default 3, meaning vertical front porch in lines.
REQ-007 SHALL have parameter VS, default 6, meaning vsync width in lines.
REQ-008 SHALL have parameter VBP, default 29, meaning vertical back porch in lines.
REQ-009 SHALL have parameter HS_POL, default 0, meaning hsync active level (0 = active-low).
REQ-010 SHALL have parameter VS_POL, default 0, meaning vsync active level (0 = active-low).
REQ-011 SHALL have port clk, input, 1 bit, pixel clock; one clock, all logic on its rising edge.
REQ-012 SHALL have port reset, input, 1 bit, reset is synchronous and active-high.
REQ-013 SHALL have port col, output, clog2(HTOT) bits, current column, where HTOT = HVID+HFP+HS+HBP (1344 by default).
REQ-014 SHALL have port row, output, clog2(VTOT) bits, current line, where VTOT = VVID+VFP+VS+VBP (806 by default).
REQ-015 SHALL have port hsync, output, 1 bit, horizontal sync at HS_POL polarity.
REQ-016 SHALL have port vsync, output, 1 bit, vertical sync at VS_POL polarity.
REQ-017 SHALL have port vid_active, output, 1 bit, high inside the visible region.
REQ-018 SHALL have port line_start, output, 1 bit, one-cycle pulse at col 0 of every line.
REQ-019 SHALL have port frame_start, output, 1 bit, one-cycle pulse at col 0, row 0.
REQ-020 SHALL have port frame_count, output, 8 bits, frame counter for animated patterns.

Function
REQ-021 SHALL increment col by 1 per clk and wrap from HTOT-1 to 0.
REQ-022 SHALL increment row only on the cycle col wraps, and wrap row from VTOT-1 to 0 in that same cycle.
REQ-023 SHALL order each line as: visible 0..HVID-1, then front porch, then sync, then back porch; frames SHALL use the same order.
REQ-024 SHALL drive vid_active high exactly when col < HVID and row < VVID.
REQ-025 SHALL drive hsync active exactly when HVID+HFP <= col < HVID+HFP+HS, and inactive otherwise.
REQ-026 SHALL drive vsync active exactly when VVID+VFP <= row < VVID+VFP+VS, and inactive otherwise; vsync edges SHALL coincide with col = 0.
REQ-027 SHALL drive hsync, vsync, vid_active, line_start and frame_start from flip-flops, with no combinational decode on the outputs, and SHALL keep them cycle-aligned with col and row (zero relative latency; decode is done from the next-count values).
REQ-028 SHALL pulse line_start high for one cycle when col = 0; SHALL pulse frame_start high for one cycle when col = 0 and row = 0.
REQ-029 SHALL increment frame_count when the counters wrap from (HTOT-1, VTOT-1) to (0, 0), and wrap it from 255 to 0.
REQ-030 SHALL keep all widths sized from HTOT and VTOT so that the wrap compare never overflows.

Reset
REQ-031 SHALL, while reset is high, hold col = 0, row = 0, frame_count = 0, vid_active = 0, line_start = 0, frame_start = 0, and hold hsync and vsync at their inactive levels (1 for the default polarity).
REQ-032 SHALL, on the first clk after reset deasserts, present col = 0, row = 0, vid_active = 1, line_start = 1, frame_start = 1 and frame_count = 0.
REQ-033 SHALL, when reset asserts mid-frame, return all outputs to their REQ-031 values on the next clk edge, with no partial line or frame retained.

Verification
REQ-034 Release reset, then run 1344 clks -> col runs 0..1343, then 0; row goes 0 -> 1 on the wrap; line_start is high at clk 0 and clk 1344 only.
REQ-035 Default parameters, row 0 -> vid_active falls at col 1024; hsync is low for cols 1048..1183 (136 cycles) and high at col 1184.
REQ-036 Run a full frame -> vsync is low for rows 771..776, with its edges at col 0; vid_active stays 0 for rows 768..805.
REQ-037 Run 256 frames (256 x 1344 x 806 clks) -> frame_count steps 0..255, then 0; frame_start fires once per frame at (0, 0).
REQ-038 Assert reset for 1 clk at col 500, row 400 -> the next cycle shows col = 0, row = 0, frame_count = 0, all pulses at 0 and syncs inactive; the following cycle shows frame_start = 1.
REQ-039 Set HS_POL = 1, VS_POL = 1 and small parameters (HVID 8, HFP 2, HS 3, HBP 1, VVID 4, VFP 1, VS 2, VBP 1) -> hsync is high for cols 10..12, vsync is high for rows 5..6, HTOT = 14 and VTOT = 8 wrap correctly.
